// File: rtl/effects_pkg.sv
// Shared types, constants and helpers for the effects_chain sample path and
// future distortion blocks that reuse the clipper.
package effects_pkg;

   typedef enum logic {
      CLIP_HARD = 1'b0,
      CLIP_SOFT = 1'b1
   } clip_mode_e;

   localparam int SOFT_SLOPE_SHIFT = 2;
   localparam int ABS_W            = 64;

   // Magnitude held unsigned, so even the most-negative input maps exactly.
   function automatic logic [ABS_W-1:0] sat_abs(input logic signed [ABS_W-1:0] v);
      if (v < 0) begin
         return $unsigned(-v);
      end
      return $unsigned(v);
   endfunction

endpackage

// File: rtl/effects_clipper.sv
// Combinational hard/soft clipper on a full-width signed value; the result
// magnitude never exceeds the threshold, so it always fits in OUT_W.
module effects_clipper
   import effects_pkg::*;
#(
   parameter int X_W   = 28,
   parameter int THR_W = 15,
   parameter int OUT_W = 16
)(
   input  logic signed [X_W-1:0]   x,
   input  logic        [THR_W-1:0] threshold,
   input  clip_mode_e              clip_mode,
   output logic signed [OUT_W-1:0] y,
   output logic                    clipped
);

   logic [ABS_W-1:0] m;
   logic [ABS_W-1:0] t;
   logic [ABS_W-1:0] k;
   logic [ABS_W-1:0] knee_out;
   logic [ABS_W-1:0] m_clip;

   // Work at ABS_W so no intermediate can wrap; knee_out is only used above the knee.
   always_comb begin
      m        = sat_abs(ABS_W'(x));
      t        = ABS_W'(threshold);
      k        = t >> 1;
      knee_out = k + ((m - k) >> SOFT_SLOPE_SHIFT);
      m_clip   = m;
      if (clip_mode == CLIP_HARD) begin
         if (m > t) begin
            m_clip = t;
         end
      end else if (m > k) begin
         m_clip = (knee_out > t) ? t : knee_out;
      end
      clipped = (m_clip != m);
      y       = x[X_W-1] ? OUT_W'(-m_clip) : OUT_W'(m_clip);
   end

endmodule

// File: rtl/effects_chain.sv
// Three-stage gain + clip sample pipeline with per-sample captured settings.
// Optional saturating clip counter enabled by defining EFFECTS_CHAIN_CLIP_COUNT_EN.
module effects_chain
   import effects_pkg::*;
#(
   parameter int IN_W      = 12,
   parameter int OUT_W     = 16,
   parameter int GAIN_W    = 11,
   parameter int GAIN_FRAC = 4,
   parameter int THR_W     = 15
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid_in,
   input  logic signed [IN_W-1:0]  sample_in,
   input  logic        [GAIN_W-1:0] gain,
   input  logic        [THR_W-1:0] threshold,
   input  logic                    clip_mode,
   input  logic                    bypass,
   output logic                    valid_out,
   output logic signed [OUT_W-1:0] sample_out,
   output logic                    clipped
`ifdef EFFECTS_CHAIN_CLIP_COUNT_EN
   ,
   input  logic                    clip_count_clr,
   output logic [15:0]             clip_count
`endif
);

   localparam int P_W = OUT_W + GAIN_W + 1;

   logic                    s1_valid;
   logic signed [OUT_W-1:0] s1_sample;
   logic        [GAIN_W-1:0] s1_gain;
   logic        [THR_W-1:0] s1_thr;
   clip_mode_e              s1_mode;
   logic                    s1_bypass;

   logic                    s2_valid;
   logic signed [P_W-1:0]   s2_x;
   logic signed [OUT_W-1:0] s2_sample;
   logic        [THR_W-1:0] s2_thr;
   clip_mode_e              s2_mode;
   logic                    s2_bypass;

   logic signed [GAIN_W:0]  gain_s;
   logic signed [P_W-1:0]   product;
   logic signed [OUT_W-1:0] clip_y;
   logic                    clip_hit;

   // Stage 1: capture the sample and its own copy of every setting.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid  <= 1'b0;
         s1_sample <= '0;
         s1_gain   <= '0;
         s1_thr    <= '0;
         s1_mode   <= CLIP_HARD;
         s1_bypass <= 1'b0;
      end else begin
         s1_valid <= valid_in;
         if (valid_in) begin
            s1_sample <= OUT_W'(sample_in);
            s1_gain   <= gain;
            s1_thr    <= threshold;
            s1_mode   <= clip_mode_e'(clip_mode);
            s1_bypass <= bypass;
         end
      end
   end

   // Gain is unsigned, so a zero sign bit makes it a safe signed operand.
   assign gain_s  = {1'b0, s1_gain};
   assign product = P_W'(s1_sample) * P_W'(gain_s);

   // Stage 2: full-width scaled value, floor shift, no truncation.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s2_valid  <= 1'b0;
         s2_x      <= '0;
         s2_sample <= '0;
         s2_thr    <= '0;
         s2_mode   <= CLIP_HARD;
         s2_bypass <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_x      <= product >>> GAIN_FRAC;
            s2_sample <= s1_sample;
            s2_thr    <= s1_thr;
            s2_mode   <= s1_mode;
            s2_bypass <= s1_bypass;
         end
      end
   end

   effects_clipper #(
      .X_W   (P_W),
      .THR_W (THR_W),
      .OUT_W (OUT_W)
   ) u_clipper (
      .x         (s2_x),
      .threshold (s2_thr),
      .clip_mode (s2_mode),
      .y         (clip_y),
      .clipped   (clip_hit)
   );

   // Stage 3: outputs only move when a sample arrives.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_out  <= 1'b0;
         sample_out <= '0;
         clipped    <= 1'b0;
      end else begin
         valid_out <= s2_valid;
         if (s2_valid) begin
            sample_out <= s2_bypass ? s2_sample : clip_y;
            clipped    <= s2_bypass ? 1'b0 : clip_hit;
         end
      end
   end

`ifdef EFFECTS_CHAIN_CLIP_COUNT_EN
   // Counts alongside the output register so it tracks clipped as seen.
   always_ff @(posedge clk) begin
      if (!rst) begin
         clip_count <= '0;
      end else if (clip_count_clr) begin
         clip_count <= '0;
      end else if (s2_valid && !s2_bypass && clip_hit && (clip_count != 16'hFFFF)) begin
         clip_count <= clip_count + 16'd1;
      end
   end
`endif

endmodule

// File: doc/effects_chain.md
Name: effects_chain

Overview:
- Parametrised successor to the single-overdrive sample path.
- Takes signed ADC samples, sign-extends them, applies a fixed-point input gain and a selectable hard or soft clipper, then saturates to the output width.
- Fully pipelined with valid tracking. Each sample carries its own copy of the control settings, so in-flight samples are never affected by a mid-stream setting change.
- Sits between the ADC capture logic and the DAC/output serializer.

Parameters:
- IN_W, 12, input sample width (signed two's complement).
- OUT_W, 16, output sample width (signed); must be ≥ IN_W.
- GAIN_W, 11, unsigned gain width.
- GAIN_FRAC, 4, fractional bits of gain; must be < GAIN_W.
- THR_W, 15, unsigned clip-threshold width; must be < OUT_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- valid_in  in  1  sample_in is valid this cycle.
- sample_in  in  IN_W  signed input sample.
- gain  in  GAIN_W  unsigned fixed-point gain (GAIN_FRAC fraction bits).
- threshold  in  THR_W  clip level, unsigned magnitude.
- clip_mode  in  1  0 = hard clip, 1 = soft clip.
- bypass  in  1  1 = pass the sign-extended sample, skipping gain and clip.
- valid_out  out  1  sample_out updated this cycle.
- sample_out  out  OUT_W  signed processed sample.
- clipped  out  1  sample_out was limited by clipping or saturation.

Behaviour:
- Reset: when rst = 0 at a clk edge, all pipeline registers are cleared: valid_out = 0, sample_out = 0, clipped = 0.
  - Reset mid-stream discards all in-flight samples; none emerge after rst is released.
- Latency: exactly 3 clk cycles from valid_in to valid_out. Throughput is 1 sample per cycle; no backpressure.
- Stage 1, when valid_in = 1:
  - Register sample_in sign-extended to OUT_W.
  - Capture gain, threshold, clip_mode and bypass into that sample's stage registers.
  - When valid_in = 0, data registers hold their values and stage valid = 0.
- Stage 2, gain:
  - Compute a signed product of width OUT_W + GAIN_W + 1.
  - Arithmetic shift right by GAIN_FRAC (floor toward −inf); no rounding.
  - Result is kept at full width; no truncation yet.
- Stage 3, clip. Let x be the stage-2 result, m = |x| computed at full width, and T = threshold.
  - Hard clip (clip_mode = 0): if m > T then m' = T, else m' = m.
  - Soft clip (clip_mode = 1): knee K = T >> 1.
    - If m ≤ K: m' = m.
    - Otherwise: m' = K + ((m − K) >> 2), then capped at T.
  - Restore the sign of x. The result always fits in OUT_W because THR_W < OUT_W.
  - clipped = 1 iff m' ≠ m.
- Bypass: the sample travels the same 3 stages with identical latency.
  - sample_out = stage-1 sign-extended value; clipped = 0.
- Outputs hold their last value while valid_out = 0.
- Edge cases:
  - Input of most-negative value with gain at maximum: the full-width product cannot overflow by construction.
  - threshold = 0 forces sample_out = 0, with clipped = 1 for any nonzero x.
  - threshold at maximum (2^THR_W − 1) with a larger magnitude clamps to that value.
- Back-to-back valid samples, each with different settings, each use their own captured settings.

Optional Feature:
- Macro: EFFECTS_CHAIN_CLIP_COUNT_EN.
- When defined, adds output clip_count [15:0]:
  - Increments on every valid_out cycle with clipped = 1.
  - Saturates at 16'hFFFF.
  - Clears on reset.
  - Has an extra input clip_count_clr; when it is high the count clears, with priority over increment.
- When not defined, neither port nor counter exists; everything else is unchanged.

Decomposition:
- Package effects_pkg holds:
  - typedef clip_mode_e (CLIP_HARD = 0, CLIP_SOFT = 1);
  - localparam SOFT_SLOPE_SHIFT = 2;
  - function sat_abs for the full-width magnitude.
- Sub-module effects_clipper: the combinational stage-3 clip (inputs x, threshold, clip_mode; outputs m' with sign and clipped). Reused by future distortion blocks.
- Pipeline registers are instantiated inline.

Test Plan:
All cases use default parameters; gain 16 = 1.0.
- Reset: drive rst = 0 with valid_in = 1 for 2 cycles, then release → valid_out = 0 and sample_out = 0 throughout; first valid_out appears 3 cycles after the first post-reset valid_in.
- Gain path: sample_in = 100, gain = 32 (2.0), threshold = 32767, hard → 3 cycles later sample_out = 200, clipped = 0; sample_in = −3, gain = 24 (1.5) → −5 (floor).
- Hard clip: sample_in = 2047, gain = 16, threshold = 1000 → sample_out = 1000, clipped = 1; sample_in = −2048 → −1000.
- Soft clip: threshold = 1000 (K = 500), sample_in = 800 → 575; −800 → −575; 400 → 400 with clipped = 0; 2047 → 886.
- Bypass and per-sample settings: 4 back-to-back valid samples alternating bypass = 1/0, with gain toggling 16/64 each cycle → each output matches its own captured settings, still 3 cycles apart.
- Optional counter (macro defined): 5 clipped samples → clip_count = 5; assert clip_count_clr simultaneously with a clipped sample → clip_count = 0.
